// File: rtl/dll_tx_arb.sv
// rtl/dll_tx_arb.sv - PCIe data-link-layer transmit arbiter (TLP / DLLP / replay onto PIPE)
//
// Ports:
//   sclk, srst_n                       clock, asynchronous active-low reset
//   dlcmsm_i[1:0]                      link state: 00 INACTIVE, 01 INIT, 10 ACTIVE, 11 reserved
//   tlp_valid_i/last_i/data_i          new-TLP beat stream,  tlp_ready_o accepts a beat
//   rpl_valid_i/last_i/data_i          replay beat stream,   rpl_ready_o accepts a beat
//   dllp_valid_i/data_i                single-beat DLLP,     dllp_ready_o accepts it
//   pipe_txdata_o/pipe_txvalid_o       registered PIPE transmit beat
//   grant_o[1:0]                       source of the current output beat: 00 none, 01 TLP, 10 DLLP, 11 replay
module dll_tx_arb #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       sclk,
  input  logic                       srst_n,
  input  logic [1:0]                 dlcmsm_i,
  input  logic                       tlp_valid_i,
  input  logic                       tlp_last_i,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
  output logic                       tlp_ready_o,
  input  logic                       rpl_valid_i,
  input  logic                       rpl_last_i,
  input  logic [PIPE_DATA_WIDTH-1:0] rpl_data_i,
  output logic                       rpl_ready_o,
  input  logic                       dllp_valid_i,
  input  logic [PIPE_DATA_WIDTH-1:0] dllp_data_i,
  output logic                       dllp_ready_o,
  output logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o,
  output logic                       pipe_txvalid_o,
  output logic [1:0]                 grant_o
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] LINK_INIT   = 2'b01;
  localparam logic [1:0] LINK_ACTIVE = 2'b10;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_TLP  = 2'b01;
  localparam logic [1:0] GNT_DLLP = 2'b10;
  localparam logic [1:0] GNT_RPL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TLP  = 2'b01,
    ST_RPL  = 2'b10
  } state_e;

  state_e                     state_q, state_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic [PIPE_DATA_WIDTH-1:0] txdata_q, txdata_d;
  logic                       txvalid_q, txvalid_d;
  logic [1:0]                 grant_q, grant_d;

  logic link_active, link_init, tlp_starved;
  logic tlp_go, rpl_go, dllp_go;

  assign link_active = (dlcmsm_i == LINK_ACTIVE);
  assign link_init   = (dlcmsm_i == LINK_INIT);
  // A pending TLP that has already waited out STARVE_LIMIT DLLPs jumps ahead of DLLPs.
  assign tlp_starved = tlp_valid_i && (starve_q == STARVE_MAX);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    tlp_ready_o  = 1'b0;
    rpl_ready_o  = 1'b0;
    dllp_ready_o = 1'b0;
    txvalid_d    = 1'b0;
    grant_d      = GNT_NONE;
    txdata_d     = txdata_q;

    case (state_q)
      ST_IDLE: begin
        if (link_active) begin
          if (rpl_valid_i)                       rpl_ready_o  = 1'b1;
          else if (dllp_valid_i && !tlp_starved) dllp_ready_o = 1'b1;
          else if (tlp_valid_i)                  tlp_ready_o  = 1'b1;
        end else if (link_init) begin
          dllp_ready_o = dllp_valid_i;
        end
      end
      // Mid-packet the owner keeps the link through valid gaps; losing ACTIVE drops it.
      ST_TLP:  tlp_ready_o = link_active;
      ST_RPL:  rpl_ready_o = link_active;
      default: ;
    endcase

    // Ready must read 0 throughout reset even though the inputs may be live.
    if (!srst_n) begin
      tlp_ready_o  = 1'b0;
      rpl_ready_o  = 1'b0;
      dllp_ready_o = 1'b0;
    end

    tlp_go  = tlp_valid_i  && tlp_ready_o;
    rpl_go  = rpl_valid_i  && rpl_ready_o;
    dllp_go = dllp_valid_i && dllp_ready_o;

    case (state_q)
      ST_IDLE: begin
        if (tlp_go && !tlp_last_i)      state_d = ST_TLP;
        else if (rpl_go && !rpl_last_i) state_d = ST_RPL;
      end
      ST_TLP:  if (!link_active || (tlp_go && tlp_last_i)) state_d = ST_IDLE;
      ST_RPL:  if (!link_active || (rpl_go && rpl_last_i)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (tlp_go)
      starve_d = '0;
    else if (dllp_go && tlp_valid_i && (starve_q != STARVE_MAX))
      starve_d = starve_q + 1'b1;

    if (tlp_go) begin
      txvalid_d = 1'b1;
      grant_d   = GNT_TLP;
      txdata_d  = tlp_data_i;
    end else if (dllp_go) begin
      txvalid_d = 1'b1;
      grant_d   = GNT_DLLP;
      txdata_d  = dllp_data_i;
    end else if (rpl_go) begin
      txvalid_d = 1'b1;
      grant_d   = GNT_RPL;
      txdata_d  = rpl_data_i;
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      txdata_q  <= '0;
      txvalid_q <= 1'b0;
      grant_q   <= GNT_NONE;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      txdata_q  <= txdata_d;
      txvalid_q <= txvalid_d;
      grant_q   <= grant_d;
    end
  end

  assign pipe_txdata_o  = txdata_q;
  assign pipe_txvalid_o = txvalid_q;
  assign grant_o        = grant_q;

endmodule

// File: tb/tb_dll_tx_arb.sv
// tb/tb_dll_tx_arb.sv - self-checking bench for dll_tx_arb
module tb_dll_tx_arb;
  localparam int W      = 256;
  localparam int STARVE = 4;
  localparam logic [1:0] L_INACT = 2'b00, L_INIT = 2'b01, L_ACT = 2'b10;

  logic sclk = 1'b0;
  logic srst_n;
  logic [1:0] dlcmsm_i;
  logic tlp_valid_i, tlp_last_i, rpl_valid_i, rpl_last_i, dllp_valid_i;
  logic [W-1:0] tlp_data_i, rpl_data_i, dllp_data_i;
  logic tlp_ready_o, rpl_ready_o, dllp_ready_o, pipe_txvalid_o;
  logic [W-1:0] pipe_txdata_o;
  logic [1:0] grant_o;

  int vectors = 0;
  int miscompares = 0;

  dll_tx_arb #(.PIPE_DATA_WIDTH(W), .STARVE_LIMIT(STARVE)) dut (
    .sclk(sclk), .srst_n(srst_n), .dlcmsm_i(dlcmsm_i),
    .tlp_valid_i(tlp_valid_i), .tlp_last_i(tlp_last_i), .tlp_data_i(tlp_data_i), .tlp_ready_o(tlp_ready_o),
    .rpl_valid_i(rpl_valid_i), .rpl_last_i(rpl_last_i), .rpl_data_i(rpl_data_i), .rpl_ready_o(rpl_ready_o),
    .dllp_valid_i(dllp_valid_i), .dllp_data_i(dllp_data_i), .dllp_ready_o(dllp_ready_o),
    .pipe_txdata_o(pipe_txdata_o), .pipe_txvalid_o(pipe_txvalid_o), .grant_o(grant_o)
  );

  always #5 sclk = ~sclk;

  // Reference model: which source currently "has the floor" (code = grant value),
  // the open packet owner, and how many DLLPs have cut in front of a waiting TLP.
  logic [1:0]   offer;
  logic         taken;
  logic [1:0]   m_open;
  int           m_starve;
  logic         m_vld;
  logic [1:0]   m_gnt;
  logic [W-1:0] m_data;

  always_comb begin
    offer = 2'd0;
    if (!srst_n)
      offer = 2'd0;
    else if (m_open != 2'd0)
      offer = (dlcmsm_i == L_ACT) ? m_open : 2'd0;
    else if (dlcmsm_i == L_ACT) begin
      if (rpl_valid_i) offer = 2'd3;
      else if (dllp_valid_i && !(tlp_valid_i && m_starve >= STARVE)) offer = 2'd2;
      else if (tlp_valid_i) offer = 2'd1;
    end else if (dlcmsm_i == L_INIT && dllp_valid_i)
      offer = 2'd2;
    taken = (offer == 2'd1 && tlp_valid_i) || (offer == 2'd2 && dllp_valid_i) || (offer == 2'd3 && rpl_valid_i);
  end

  always @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      m_open <= 2'd0; m_starve <= 0; m_vld <= 1'b0; m_gnt <= 2'd0; m_data <= '0;
    end else begin
      m_vld <= taken;
      m_gnt <= taken ? offer : 2'd0;
      if (taken) m_data <= (offer == 2'd1) ? tlp_data_i : (offer == 2'd2) ? dllp_data_i : rpl_data_i;
      if (taken && offer == 2'd1) m_starve <= 0;
      else if (taken && offer == 2'd2 && tlp_valid_i && m_starve < STARVE) m_starve <= m_starve + 1;
      if (m_open != 2'd0) begin
        if (dlcmsm_i != L_ACT) m_open <= 2'd0;
        else if (taken && ((offer == 2'd1 && tlp_last_i) || (offer == 2'd3 && rpl_last_i))) m_open <= 2'd0;
      end else if (taken && offer == 2'd1 && !tlp_last_i) m_open <= 2'd1;
      else if (taken && offer == 2'd3 && !rpl_last_i) m_open <= 2'd3;
    end
  end

  wire [6:0] obs  = {tlp_ready_o, rpl_ready_o, dllp_ready_o, pipe_txvalid_o, grant_o};
  wire [6:0] expv = {offer == 2'd1, offer == 2'd3, offer == 2'd2, m_vld, m_gnt};

  logic [1:0] gseq[$];
  logic [1:0] eseq[$];
  always @(negedge sclk) if (pipe_txvalid_o) gseq.push_back(grant_o);

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    tlp_valid_i = 0; tlp_last_i = 0; rpl_valid_i = 0; rpl_last_i = 0; dllp_valid_i = 0;
    tlp_data_i = rnd(); rpl_data_i = rnd(); dllp_data_i = rnd();
  endtask

  task automatic next_cycle();
    @(posedge sclk); #1;
  endtask

  task automatic test_reset();
    srst_n = 0; dlcmsm_i = L_ACT; idle_inputs();
    tlp_valid_i = 1; rpl_valid_i = 1; dllp_valid_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge sclk);
      vectors++;
      if (obs !== 7'd0 || pipe_txdata_o !== '0) begin
        miscompares++;
        $display("FAIL reset c%0d: rdy/vld/gnt=%b data=%h required all zero", c, obs, pipe_txdata_o);
      end
    end
    next_cycle();
    srst_n = 1; idle_inputs();
    next_cycle();
  endtask

  task automatic test_tlp_then_dllp();
    gseq.delete();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      tlp_valid_i = (c < 3); tlp_last_i = (c == 2); dllp_valid_i = (c >= 1 && c <= 3);
      @(negedge sclk);
      vectors++;
      if (obs !== expv || pipe_txdata_o !== m_data) begin
        miscompares++;
        $display("FAIL tlp_then_dllp c%0d: rdy/vld/gnt=%b exp %b data=%h exp %h", c, obs, expv, pipe_txdata_o, m_data);
      end
      next_cycle();
    end
    eseq = '{2'b01, 2'b01, 2'b01, 2'b10};
    vectors++;
    if (gseq != eseq) begin
      miscompares++;
      $display("FAIL tlp_then_dllp grant sequence: %0d grants seen, 4 required (01,01,01,10)", gseq.size());
    end
  endtask

  task automatic test_priority();
    gseq.delete();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      rpl_valid_i = (c == 0); rpl_last_i = 1; dllp_valid_i = (c <= 1);
      tlp_valid_i = (c <= 2); tlp_last_i = 1;
      @(negedge sclk);
      vectors++;
      if (obs !== expv || pipe_txdata_o !== m_data) begin
        miscompares++;
        $display("FAIL priority c%0d: rdy/vld/gnt=%b exp %b data=%h exp %h", c, obs, expv, pipe_txdata_o, m_data);
      end
      next_cycle();
    end
    eseq = '{2'b11, 2'b10, 2'b01};
    vectors++;
    if (gseq != eseq) begin
      miscompares++;
      $display("FAIL priority grant sequence: %0d grants seen, required 11,10,01", gseq.size());
    end
  endtask

  task automatic test_starve();
    gseq.delete();
    for (int c = 0; c < 17; c++) begin
      idle_inputs();
      dllp_valid_i = (c < 15); tlp_valid_i = (c < 15); tlp_last_i = 1;
      @(negedge sclk);
      vectors++;
      if (obs !== expv || pipe_txdata_o !== m_data) begin
        miscompares++;
        $display("FAIL starve c%0d: rdy/vld/gnt=%b exp %b data=%h exp %h", c, obs, expv, pipe_txdata_o, m_data);
      end
      next_cycle();
    end
    eseq.delete();
    for (int i = 0; i < 15; i++) eseq.push_back((i % (STARVE + 1) == STARVE) ? 2'b01 : 2'b10);
    vectors++;
    if (gseq != eseq) begin
      miscompares++;
      $display("FAIL starve grant sequence: %0d grants seen, 15 required in 4xDLLP+1xTLP pattern", gseq.size());
    end
  endtask

  task automatic test_init();
    gseq.delete();
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      dlcmsm_i = (c < 6) ? L_INIT : L_ACT;
      dllp_valid_i = (c <= 6); tlp_valid_i = (c <= 6); tlp_last_i = 1;
      @(negedge sclk);
      vectors++;
      if (c <= 6 && tlp_ready_o !== (c == 6)) begin
        miscompares++;
        $display("FAIL init tlp_ready c%0d: got %b required %b", c, tlp_ready_o, c == 6);
      end
      vectors++;
      if (obs !== expv || pipe_txdata_o !== m_data) begin
        miscompares++;
        $display("FAIL init c%0d: rdy/vld/gnt=%b exp %b data=%h exp %h", c, obs, expv, pipe_txdata_o, m_data);
      end
      next_cycle();
    end
    eseq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    vectors++;
    if (gseq != eseq) begin
      miscompares++;
      $display("FAIL init grant sequence: %0d grants seen, required 6xDLLP then TLP", gseq.size());
    end
  endtask

  task automatic test_link_drop();
    gseq.delete();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      dlcmsm_i = (c == 2 || c == 3) ? L_INACT : L_ACT;
      tlp_valid_i = (c < 4); tlp_last_i = (c == 3);
      @(negedge sclk);
      if (c == 2 || c == 3) begin
        vectors++;
        if (tlp_ready_o !== 1'b0 || (c == 3 && pipe_txvalid_o !== 1'b0)) begin
          miscompares++;
          $display("FAIL link_drop c%0d: tlp_ready=%b txvalid=%b required 0", c, tlp_ready_o, pipe_txvalid_o);
        end
      end
      vectors++;
      if (obs !== expv || pipe_txdata_o !== m_data) begin
        miscompares++;
        $display("FAIL link_drop c%0d: rdy/vld/gnt=%b exp %b data=%h exp %h", c, obs, expv, pipe_txdata_o, m_data);
      end
      next_cycle();
    end
    eseq = '{2'b01, 2'b01};
    vectors++;
    if (gseq != eseq) begin
      miscompares++;
      $display("FAIL link_drop grant sequence: %0d grants seen, 2 required", gseq.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c == 2) begin srst_n = 1; gseq.delete(); end
      rpl_valid_i = (c != 5 && c != 6); rpl_last_i = (c == 4);
      if (c == 1) begin
        #1 srst_n = 0;
        #1;
        vectors++;
        if (obs !== 7'd0 || pipe_txdata_o !== '0) begin
          miscompares++;
          $display("FAIL reset_mid async: rdy/vld/gnt=%b data=%h required all zero", obs, pipe_txdata_o);
        end
      end
      @(negedge sclk);
      vectors++;
      if (obs !== expv || pipe_txdata_o !== m_data) begin
        miscompares++;
        $display("FAIL reset_mid c%0d: rdy/vld/gnt=%b exp %b data=%h exp %h", c, obs, expv, pipe_txdata_o, m_data);
      end
      next_cycle();
    end
    eseq = '{2'b11, 2'b11, 2'b11};
    vectors++;
    if (gseq != eseq) begin
      miscompares++;
      $display("FAIL reset_mid grant sequence: %0d grants seen, required 11,11,11", gseq.size());
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      dlcmsm_i = (r == 0) ? L_INACT : (r == 1) ? L_INIT : (r == 2) ? 2'b11 : L_ACT;
      tlp_valid_i  = ($urandom_range(0, 3) != 0);
      rpl_valid_i  = ($urandom_range(0, 4) == 0);
      dllp_valid_i = ($urandom_range(0, 2) == 0);
      tlp_last_i   = ($urandom_range(0, 2) == 0);
      rpl_last_i   = ($urandom_range(0, 2) == 0);
      tlp_data_i = rnd(); rpl_data_i = rnd(); dllp_data_i = rnd();
      @(negedge sclk);
      vectors++;
      if (obs !== expv || pipe_txdata_o !== m_data) begin
        miscompares++;
        $display("FAIL random c%0d: rdy/vld/gnt=%b exp %b data=%h exp %h", c, obs, expv, pipe_txdata_o, m_data);
      end
      next_cycle();
    end
  endtask

  initial begin
    srst_n = 0; dlcmsm_i = L_INACT; idle_inputs();
    #2;
    test_reset();
    dlcmsm_i = L_ACT;
    test_tlp_then_dllp();
    test_priority();
    test_starve();
    test_init();
    test_link_drop();
    dlcmsm_i = L_ACT;
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
